wb_pipe: RTL
============

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 The block SHALL have these parameters: WIDTH, default 16, data width; NSRC, default 4, number of write-back sources; SELW, default 2, select width; REGW, default 3, register-address width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, sole clock, all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, MEM stage presents an instruction.
- stall, input, 1, hold WB register contents.
- flush, input, 1, kill the entry being captured.
- src_data, input, NSRC*WIDTH, packed sources; source k at bits [k*WIDTH +: WIDTH].
- src_sel, input, SELW, source index.
- in_rd, input, REGW, destination register.
- in_we, input, 1, instruction writes the register file.
- rs_addr, input, REGW, forwarding query address.
- out_valid, output, 1, WB entry valid.
- wbdata, output, WIDTH, write-back data.
- wbreg, output, REGW, write-back register.
- wbwe, output, 1, register-file write enable.
- fwd_hit, output, 1, query matches pending write.
- fwd_data, output, WIDTH, forwarded value.
- wb_count, output, 16, retired-write counter.

Function
REQ-003 The source mux SHALL be combinational and feed the WB register: selected = source src_sel when src_sel < NSRC, else all zeros.
REQ-004 On a rising edge with rst=0, flush=0 and stall=0, the block SHALL load out_valid<=in_valid, wbdata<=selected, wbreg<=in_rd, and an internal we_q<=in_we.
REQ-005 Latency SHALL be exactly one cycle from the capture edge to wbdata/wbreg/wbwe.
REQ-006 When stall=1 and flush=0, all registers, including wb_count, SHALL hold their values; inputs are ignored.
REQ-007 When flush=1, out_valid and we_q SHALL clear on the next edge regardless of stall; wbdata and wbreg are don't-care; flush has priority over stall.
REQ-008 wbwe SHALL equal out_valid AND we_q, combinationally; a register write never occurs for an invalid entry.
REQ-009 fwd_hit SHALL equal wbwe AND (rs_addr == wbreg), combinationally; fwd_data SHALL equal wbdata whenever fwd_hit=1 and SHALL be zero otherwise.
REQ-010 wb_count SHALL increment by 1 on each edge where a capture per REQ-004 occurs with in_valid=1 and in_we=1.
REQ-011 wb_count SHALL wrap from 0xFFFF to 0x0000 with no sticky flag.
REQ-012 Simultaneous events SHALL be resolved in priority order rst > flush > stall > capture.
REQ-013 The block SHALL contain no combinational path from src_data to wbdata.

Reset
REQ-014 On an edge with rst=1, out_valid, we_q, wbreg, wbdata and wb_count SHALL all be 0.
REQ-015 Consequently wbwe, fwd_hit and fwd_data SHALL be 0 during and after reset until the first capture.
REQ-016 Reset asserted during a stall or flush SHALL clear all state identically to REQ-014.

Verification
REQ-017 Basic select: the bench SHALL drive sources 0x1111/0x2222/0x3333/0x4444, sel=2, rd=5, we=1, valid=1 and require, one cycle later, wbdata=0x3333, wbreg=5, wbwe=1, wb_count=1.
REQ-018 Stall hold: the bench SHALL capture sel=1, then hold stall=1 for 3 cycles while changing all inputs, and require wbdata=0x2222 and wb_count unchanged for all 3 cycles.
REQ-019 Flush over stall: with a valid entry loaded, the bench SHALL assert stall=1 and flush=1 together and require out_valid=0 and wbwe=0 on the next cycle.
REQ-020 Forwarding: after capturing rd=3, we=1, the bench SHALL require rs_addr=3 to give fwd_hit=1 with fwd_data=wbdata, rs_addr=4 to give fwd_hit=0 with fwd_data=0, and a capture with we=0 to give fwd_hit=0.
REQ-021 Out-of-range select: with NSRC=3 and SELW=2, the bench SHALL capture sel=3 and require wbdata=0x0000.
REQ-022 Wrap and reset: the bench SHALL perform 65536 valid writes and require wb_count=0; it SHALL then assert rst during a stall and require all outputs to be 0 on the next cycle.

Source files
------------

// File: rtl/wb_pipe.sv
// -----------------------------------------------------------------------------
// wb_pipe -- write-back stage register of an in-order pipeline.
//
// Selects one of NSRC result sources coming out of the MEM stage, registers
// it together with the destination register and write enable, and presents
// the registered entry to the register file. A forwarding port compares a
// read address against the pending write so earlier stages can bypass the
// register file. A 16-bit counter tracks how many register writes retired.
//
// Parameters
//   WIDTH  data width
//   NSRC   number of write-back sources
//   SELW   width of the source select
//   REGW   register-address width
//
// Ports
//   clk        in   1           sole clock, all state on rising edge
//   rst        in   1           synchronous active-high reset
//   in_valid   in   1           MEM stage presents an instruction
//   stall      in   1           hold WB register contents
//   flush      in   1           kill the entry being captured
//   src_data   in   NSRC*WIDTH  packed sources, source k at [k*WIDTH +: WIDTH]
//   src_sel    in   SELW        source index
//   in_rd      in   REGW        destination register
//   in_we      in   1           instruction writes the register file
//   rs_addr    in   REGW        forwarding query address
//   out_valid  out  1           WB entry valid
//   wbdata     out  WIDTH       write-back data (registered)
//   wbreg      out  REGW        write-back register (registered)
//   wbwe       out  1           register-file write enable
//   fwd_hit    out  1           query matches the pending write
//   fwd_data   out  WIDTH       forwarded value, zero when no hit
//   wb_count   out  16          retired-write counter, wraps silently
//
// Transfer semantics: in_valid qualifies the MEM-side payload (src_data,
// src_sel, in_rd, in_we) on every rising edge where the stage is not held;
// there is no ready signal. stall is the only back-pressure: while it is
// high the MEM stage must keep its payload and the WB entry does not move.
// out_valid qualifies wbdata/wbreg; wbwe is never high for an invalid entry.
// Event priority on an edge: rst > flush > stall > capture.
// -----------------------------------------------------------------------------
module wb_pipe #(
   parameter int WIDTH = 16,
   parameter int NSRC  = 4,
   parameter int SELW  = 2,
   parameter int REGW  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [NSRC*WIDTH-1:0]   src_data,
   input  logic [SELW-1:0]         src_sel,
   input  logic [REGW-1:0]         in_rd,
   input  logic                    in_we,
   input  logic [REGW-1:0]         rs_addr,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        wbdata,
   output logic [REGW-1:0]         wbreg,
   output logic                    wbwe,
   output logic                    fwd_hit,
   output logic [WIDTH-1:0]        fwd_data,
   output logic [15:0]             wb_count
);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic             valid_q, valid_d;
   logic             we_q,    we_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [REGW-1:0]  reg_q,   reg_d;
   logic [15:0]      count_q, count_d;

   // --------------------------------------------------------------------------
   // Source mux
   // --------------------------------------------------------------------------
   logic [WIDTH-1:0] selected;
   logic [31:0]      sel_ext;

   // The select is widened before comparing so that, when NSRC exceeds
   // 2**SELW, high source indices never alias onto low ones; any select
   // value without a matching source yields zero.
   always_comb begin
      selected = '0;
      sel_ext  = 32'(src_sel);
      for (int k = 0; k < NSRC; k++) begin
         if (sel_ext == 32'(k)) begin
            selected = src_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   logic capture;
   logic retire;

   assign capture = !flush && !stall;
   assign retire  = capture && in_valid && in_we;

   always_comb begin
      valid_d = valid_q;
      we_d    = we_q;
      data_d  = data_q;
      reg_d   = reg_q;
      count_d = count_q;

      if (flush) begin
         // Only the qualifiers are cleared; the payload is left as-is since
         // nothing downstream looks at it while out_valid is low.
         valid_d = 1'b0;
         we_d    = 1'b0;
      end else if (!stall) begin
         valid_d = in_valid;
         we_d    = in_we;
         data_d  = selected;
         reg_d   = in_rd;
      end

      // Counts writes entering WB; natural 16-bit overflow gives the wrap.
      if (retire) begin
         count_d = count_q + 16'd1;
      end
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         data_q  <= '0;
         reg_q   <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         data_q  <= data_d;
         reg_q   <= reg_d;
         count_q <= count_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // wbdata comes straight from a flop, so src_data never reaches it
   // combinationally.
   assign out_valid = valid_q;
   assign wbdata    = data_q;
   assign wbreg     = reg_q;
   assign wb_count  = count_q;

   assign wbwe      = valid_q && we_q;
   assign fwd_hit   = wbwe && (rs_addr == reg_q);
   assign fwd_data  = fwd_hit ? data_q : '0;

endmodule
